// File: rtl/mixed_wake_scheduler.sv
// Round-robin wake scheduler merging event-style and edge-detected
// level triggers into one valid/ready grant stream with timestamps.
module mixed_wake_scheduler #(
  parameter  int NUM_SRC    = 4,
  parameter  int CNT_W      = 32,
  parameter  int WAKE_LIMIT = 2,
  localparam int SW         = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_mode,
  input  logic [NUM_SRC-1:0] src_in,
  output logic               wake_valid,
  input  logic               wake_ready,
  output logic [SW-1:0]      wake_src,
  output logic [CNT_W-1:0]   wake_time,
  output logic [NUM_SRC-1:0] pending,
  output logic               overflow,
  output logic               done,
  output logic [CNT_W-1:0]   cyc
);

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [NUM_SRC-1:0] prev_in;
  logic [NUM_SRC-1:0] trig;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] pend_nxt;
  logic [SW-1:0]      rr_ptr;
  logic [SW-1:0]      rr_nxt;
  logic [SW-1:0]      sel;
  logic [SW:0]        idx;
  logic               found;
  logic [CNT_W-1:0]   wake_count;
  logic               hs;
  logic               grant;
  logic               limit_hit;

  assign trig = (src_mode & src_in & ~prev_in)
              | (~src_mode & src_in);

  assign wake_valid = (state == OFFER);
  assign done       = (state == DONE);
  assign hs         = wake_valid & wake_ready;
  assign grant      = (state == IDLE) & (|pending);

  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_SRC; i++)
      clr[i] = hs && (wake_src == SW'(i));
  end

  // a retrigger landing on its own clear cycle re-arms the bit
  assign pend_nxt = (pending & ~clr) | trig;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = {1'b0, rr_ptr} + (SW+1)'(k);
      if (idx >= (SW+1)'(NUM_SRC))
        idx = idx - (SW+1)'(NUM_SRC);
      if (!found && pending[idx[SW-1:0]]) begin
        found = 1'b1;
        sel   = idx[SW-1:0];
      end
    end
  end

  assign rr_nxt = (wake_src == SW'(NUM_SRC-1)) ?
                  '0 : wake_src + SW'(1);

  assign limit_hit = (WAKE_LIMIT != 0) &&
    (({1'b0, wake_count} + (CNT_W+1)'(1))
      == (CNT_W+1)'(WAKE_LIMIT));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (|pending) state_nxt = OFFER;
      OFFER:   if (wake_ready)
                 state_nxt = limit_hit ? DONE : IDLE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc      <= '0;
      prev_in  <= '0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      cyc     <= cyc + CNT_W'(1);
      prev_in <= src_in;
      pending <= pend_nxt;
      if (|(trig & pending & ~clr))
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wake_src   <= '0;
      wake_time  <= '0;
      rr_ptr     <= '0;
      wake_count <= '0;
    end else begin
      if (grant) begin
        wake_src  <= sel;
        wake_time <= cyc;
      end
      if (hs) begin
        rr_ptr <= rr_nxt;
        if (wake_count != '1)
          wake_count <= wake_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mixed_wake_scheduler.sv
// Random and directed stimulus against a cycle-level behavioural model
// of the wake scheduler.
module tb_mixed_wake_scheduler;

  localparam int N     = 4;
  localparam int CW    = 8;
  localparam int LIMIT = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  src_mode = '0;
  logic [N-1:0]  src_in = '0;
  logic          wake_ready = 1'b0;
  logic          wake_valid;
  logic [1:0]    wake_src;
  logic [CW-1:0] wake_time;
  logic [N-1:0]  pending;
  logic          overflow;
  logic          done;
  logic [CW-1:0] cyc;

  mixed_wake_scheduler #(
    .NUM_SRC(N), .CNT_W(CW), .WAKE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .src_mode(src_mode), .src_in(src_in),
    .wake_valid(wake_valid), .wake_ready(wake_ready),
    .wake_src(wake_src), .wake_time(wake_time),
    .pending(pending), .overflow(overflow),
    .done(done), .cyc(cyc)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  int       m_cyc, m_src, m_time, m_rr, m_count;
  bit [N-1:0] m_prev, m_pend;
  bit       m_ovf, m_offer, m_done;
  int       hs_log_src[$];
  int       hs_log_time[$];

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_cyc = 0; m_src = 0; m_time = 0; m_rr = 0;
    m_count = 0; m_prev = '0; m_pend = '0;
    m_ovf = 0; m_offer = 0; m_done = 0;
  endfunction

  function automatic void model_step(bit [N-1:0] mode,
                                     bit [N-1:0] in, bit rdy);
    bit [N-1:0] trig, clr, old_pend;
    bit hs, hit;
    int idx;
    old_pend = m_pend;
    for (int i = 0; i < N; i++)
      trig[i] = mode[i] ? (in[i] && !m_prev[i]) : in[i];
    hs  = m_offer && rdy;
    clr = '0;
    if (hs) clr[m_src] = 1'b1;
    if ((trig & m_pend & ~clr) != 0) m_ovf = 1;
    m_pend = (m_pend & ~clr) | trig;
    if (m_offer) begin
      if (rdy) begin
        m_offer = 0;
        m_rr = (m_src + 1) % N;
        if (m_count < 255) m_count++;
        if (LIMIT != 0 && m_count == LIMIT) m_done = 1;
      end
    end else if (!m_done && old_pend != 0) begin
      hit = 0;
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (!hit && old_pend[idx]) begin
          hit = 1; m_offer = 1;
          m_src = idx; m_time = m_cyc;
        end
      end
    end
    m_cyc = (m_cyc + 1) % 256;
    m_prev = in;
  endfunction

  task automatic check_all();
    check("cyc", cyc, m_cyc);
    check("wake_valid", wake_valid, m_offer);
    if (m_offer) begin
      check("wake_src", wake_src, m_src);
      check("wake_time", wake_time, m_time);
    end
    check("pending", pending, m_pend);
    check("overflow", overflow, m_ovf);
    check("done", done, m_done);
  endtask

  // called just after a negedge; returns just after the next one
  task automatic cycle(bit [N-1:0] mode, bit [N-1:0] in,
                       bit rdy);
    src_mode = mode; src_in = in; wake_ready = rdy;
    #1;
    if (wake_valid && wake_ready) begin
      hs_log_src.push_back(int'(wake_src));
      hs_log_time.push_back(int'(wake_time));
    end
    model_step(mode, in, rdy);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    hs_log_src.delete();
    hs_log_time.delete();
  endtask

  function automatic bit [N-1:0] rnd_bits(int pct);
    bit [N-1:0] v;
    for (int i = 0; i < N; i++)
      v[i] = ($urandom_range(99) < pct);
    return v;
  endfunction

  initial begin
    bit [N-1:0] md, in;
    int len, w;
    model_reset();
    @(negedge clk);
    do_reset();

    // src0 level edge, src1 event pulse
    for (int j = 0; j < 12; j++) begin
      in = '0;
      if (j == 2) in[1] = 1'b1;
      if (j >= 4) in[0] = 1'b1;
      cycle(4'b0001, in, 1'b1);
    end
    check("tp1_nwakes", hs_log_src.size(), 2);
    if (hs_log_src.size() == 2) begin
      check("tp1_src0", hs_log_src[0], 1);
      check("tp1_time0", hs_log_time[0], 3);
      check("tp1_src1", hs_log_src[1], 0);
      check("tp1_time1", hs_log_time[1], 5);
    end

    // held event source while not ready -> overflow, one wake
    do_reset();
    for (int j = 0; j < 3; j++) cycle('0, 4'b0010, 1'b0);
    for (int j = 0; j < 3; j++) cycle('0, '0, 1'b0);
    for (int j = 0; j < 6; j++) cycle('0, '0, 1'b1);
    check("tp2_nwakes", hs_log_src.size(), 1);

    // all sources at once, twice: round-robin wrap and done
    do_reset();
    for (int r = 0; r < 2; r++) begin
      cycle('0, 4'b1111, 1'b1);
      for (int j = 0; j < 10; j++) cycle('0, '0, 1'b1);
    end
    check("tp3_nwakes", hs_log_src.size(), LIMIT);

    // stall offer while src2 triggers
    do_reset();
    cycle('0, 4'b0001, 1'b0);
    cycle('0, '0, 1'b0);
    cycle('0, 4'b0100, 1'b0);
    for (int j = 0; j < 4; j++) cycle('0, '0, 1'b0);
    for (int j = 0; j < 6; j++) cycle('0, '0, 1'b1);

    // retrigger src0 on its own handshake
    do_reset();
    cycle('0, 4'b0001, 1'b0);
    cycle('0, '0, 1'b0);
    cycle('0, 4'b0001, 1'b1);
    for (int j = 0; j < 5; j++) cycle('0, '0, 1'b1);
    check("tp5_nwakes", hs_log_src.size(), 2);

    // reset during an offer
    cycle('0, 4'b0010, 1'b0);
    w = 0;
    while (!m_offer && w < 10) begin
      cycle('0, '0, 1'b0);
      w++;
    end
    check("tp6_in_offer", wake_valid, 1'b1);
    do_reset();

    // random episodes
    for (int e = 0; e < 40; e++) begin
      do_reset();
      md  = rnd_bits(50);
      len = (e == 7) ? 400 : int'($urandom_range(120, 20));
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(15) == 0)
          md[$urandom_range(N-1)] ^= 1'b1;
        in = rnd_bits(25);
        cycle(md, in, ($urandom_range(99) < 60));
        if ($urandom_range(199) == 0) do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
